// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - fetch_state_e : FSM state encoding (also exported on state_o for debug)
//   - FETCH_*       : default widths, reset/interrupt vectors, bus wait limit
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } fetch_state_e;

    localparam int unsigned FETCH_ADDR_W      = 12;
    localparam int unsigned FETCH_INST_W      = 18;
    localparam int unsigned FETCH_RESET_PC    = 0;
    localparam int unsigned FETCH_INT_VEC     = 1;
    localparam int unsigned FETCH_TIMEOUT_CYC = 15;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// ----------------------------------------------------------------------------
// fetch_timeout_ctr
// Bus wait counter with limit compare. Counts cycles in which a request is
// outstanding without acknowledge; expired_o pulses on the cycle whose edge
// would complete the LIMIT-th such wait cycle.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : restart the count (no request, ack, or new transaction)
//   inc_i        : one more cycle waited without ack
//   expired_o    : wait limit reached this cycle
// ----------------------------------------------------------------------------
module fetch_timeout_ctr
    import fetch_pkg::*;
#(
    parameter int unsigned LIMIT = FETCH_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter; clear has priority over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc_i) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired_o = inc_i && !clr_i && (cnt_r == LAST_CNT);

endmodule

// File: rtl/inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch stage: program counter, single-outstanding req/ack fetch
// on the instruction bus, and an instruction register handed to the control
// unit with a valid/ready handshake. Branch/jump/return targets and interrupt
// entry redirect the fetch PC (interrupt wins over redirect).
// Optional feature macro: FETCH_TIMEOUT_EN (bus wait timeout, sticky
// fetch_err_o, FSM parks in S_HOLD until reset).
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   inst_cyc_o/stb_o/adr_o        : bus request, held until acknowledged
//   inst_dat_i/ack_i              : bus response
//   ir_o, ir_valid_o, ir_ready_i  : instruction handshake to control unit
//   pc_o                          : address of the instruction in ir_o
//   redirect_i, redirect_pc_i     : load a new fetch address
//   int_take_i                    : interrupt entry, fetch from INT_VEC
//   fetch_err_o                   : sticky bus timeout flag
//   state_o                       : FSM state for debug
// ----------------------------------------------------------------------------
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W      = FETCH_ADDR_W,
    parameter int unsigned        INST_W      = FETCH_INST_W,
    parameter logic [ADDR_W-1:0]  RESET_PC    = ADDR_W'(FETCH_RESET_PC),
    parameter logic [ADDR_W-1:0]  INT_VEC     = ADDR_W'(FETCH_INT_VEC),
    parameter int unsigned        TIMEOUT_CYC = FETCH_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              inst_cyc_o,
    output logic              inst_stb_o,
    output logic [ADDR_W-1:0] inst_adr_o,
    input  logic [INST_W-1:0] inst_dat_i,
    input  logic              inst_ack_i,
    output logic [INST_W-1:0] ir_o,
    output logic              ir_valid_o,
    input  logic              ir_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              int_take_i,
    output logic              fetch_err_o,
    output logic [1:0]        state_o
);

    fetch_state_e      state_r;
    logic              bus_req_r;   // drives both cyc and stb
    logic [ADDR_W-1:0] adr_r;       // address of the outstanding request
    logic [ADDR_W-1:0] fetch_pc_r;  // next fetch address (latched target in S_FLUSH)
    logic [INST_W-1:0] ir_r;
    logic              valid_r;
    logic [ADDR_W-1:0] pc_r;

    logic              jump_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic              timeout_s;
    logic              park_s;

    // Redirect target selection (interrupt beats redirect) and PC increment.
    always_comb begin
        jump_s   = int_take_i | redirect_i;
        pc_inc_s = fetch_pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (int_take_i) begin
            target_s = INT_VEC;
        end else begin
            target_s = redirect_pc_i;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic tmo_clr_s;
    logic tmo_inc_s;
    logic err_r;

    // A redirect in S_FETCH without ack enters S_FLUSH and restarts the wait.
    assign tmo_inc_s = bus_req_r & ~inst_ack_i;
    assign tmo_clr_s = ~bus_req_r | inst_ack_i | ((state_r == S_FETCH) & jump_s);

    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmo_clr_s),
        .inc_i     (tmo_inc_s),
        .expired_o (timeout_s)
    );

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign park_s      = err_r;
    assign fetch_err_o = err_r;
`else
    assign timeout_s   = 1'b0;
    assign park_s      = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    // Fetch FSM with PC, bus request and instruction register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= S_RESET;
            bus_req_r  <= 1'b0;
            adr_r      <= RESET_PC;
            fetch_pc_r <= RESET_PC;
            ir_r       <= {INST_W{1'b0}};
            valid_r    <= 1'b0;
            pc_r       <= RESET_PC;
        end else begin
            case (state_r)
                S_RESET: begin
                    state_r   <= S_FETCH;
                    bus_req_r <= 1'b1;
                    adr_r     <= fetch_pc_r;
                end
                S_FETCH: begin
                    if (!bus_req_r) begin
                        // One-cycle gap after a discarded ack; start the new fetch.
                        bus_req_r <= 1'b1;
                        if (jump_s) begin
                            adr_r      <= target_s;
                            fetch_pc_r <= target_s;
                        end else begin
                            adr_r <= fetch_pc_r;
                        end
                    end else if (timeout_s) begin
                        bus_req_r <= 1'b0;
                        state_r   <= S_HOLD;
                    end else if (inst_ack_i) begin
                        bus_req_r <= 1'b0;
                        if (jump_s) begin
                            fetch_pc_r <= target_s;
                        end else begin
                            ir_r       <= inst_dat_i;
                            pc_r       <= fetch_pc_r;
                            fetch_pc_r <= pc_inc_s;
                            valid_r    <= 1'b1;
                            state_r    <= S_HOLD;
                        end
                    end else if (jump_s) begin
                        // Request must complete; remember where to go afterwards.
                        fetch_pc_r <= target_s;
                        state_r    <= S_FLUSH;
                    end else begin
                        bus_req_r <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (timeout_s) begin
                        bus_req_r <= 1'b0;
                        state_r   <= S_HOLD;
                    end else if (inst_ack_i) begin
                        // Data dropped; the next request follows without a gap.
                        state_r <= S_FETCH;
                        if (jump_s) begin
                            adr_r      <= target_s;
                            fetch_pc_r <= target_s;
                        end else begin
                            adr_r <= fetch_pc_r;
                        end
                    end else if (jump_s) begin
                        fetch_pc_r <= target_s;
                    end else begin
                        bus_req_r <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (park_s) begin
                        valid_r <= 1'b0;
                    end else if (jump_s) begin
                        valid_r    <= 1'b0;
                        fetch_pc_r <= target_s;
                        adr_r      <= target_s;
                        bus_req_r  <= 1'b1;
                        state_r    <= S_FETCH;
                    end else if (ir_ready_i) begin
                        valid_r   <= 1'b0;
                        adr_r     <= fetch_pc_r;
                        bus_req_r <= 1'b1;
                        state_r   <= S_FETCH;
                    end else begin
                        valid_r <= valid_r;
                    end
                end
                default: begin
                    state_r   <= S_RESET;
                    bus_req_r <= 1'b0;
                    valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign inst_cyc_o = bus_req_r;
    assign inst_stb_o = bus_req_r;
    assign inst_adr_o = adr_r;
    assign ir_o       = ir_r;
    assign ir_valid_o = valid_r;
    assign pc_o       = pc_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        inst_cyc_o;
    logic        inst_stb_o;
    logic [11:0] inst_adr_o;
    logic [17:0] inst_dat_i = 18'h0;
    logic        inst_ack_i = 1'b0;
    logic [17:0] ir_o;
    logic        ir_valid_o;
    logic        ir_ready_i = 1'b0;
    logic [11:0] pc_o;
    logic        redirect_i = 1'b0;
    logic [11:0] redirect_pc_i = 12'h0;
    logic        int_take_i = 1'b0;
    logic        fetch_err_o;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] mem [4096];

    inst_fetch_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inst_cyc_o   (inst_cyc_o),
        .inst_stb_o   (inst_stb_o),
        .inst_adr_o   (inst_adr_o),
        .inst_dat_i   (inst_dat_i),
        .inst_ack_i   (inst_ack_i),
        .ir_o         (ir_o),
        .ir_valid_o   (ir_valid_o),
        .ir_ready_i   (ir_ready_i),
        .pc_o         (pc_o),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .int_take_i   (int_take_i),
        .fetch_err_o  (fetch_err_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cyc"},   32'(inst_cyc_o), 32'd0);
        chk({tag, "_stb"},   32'(inst_stb_o), 32'd0);
        chk({tag, "_adr"},   32'(inst_adr_o), 32'd0);
        chk({tag, "_ir"},    32'(ir_o),       32'd0);
        chk({tag, "_valid"}, 32'(ir_valid_o), 32'd0);
        chk({tag, "_pc"},    32'(pc_o),       32'd0);
        chk({tag, "_err"},   32'(fetch_err_o), 32'd0);
        chk({tag, "_state"}, 32'(state_o),    32'd0);
    endtask

    initial begin
        logic [11:0] exp_pc;
        logic        prev_stb, prev_ack, prev_valid;
        logic [11:0] prev_adr;
        int          wait_cnt, delay, n_seen;

        for (int i = 0; i < 4096; i++) mem[i] = 18'($urandom);

        // ---- reset state ----
        tick(); tick();
        chk_reset_values("reset");

        // ---- zero-wait ack, ready held high ----
        inst_ack_i = 1'b1; inst_dat_i = 18'h38A8C; ir_ready_i = 1'b1;
        rst_i = 1'b0;
        chk("t1_stb_pre", 32'(inst_stb_o), 32'd0);
        tick();
        chk("t1_stb0", 32'(inst_stb_o), 32'd1);
        chk("t1_cyc0", 32'(inst_cyc_o), 32'd1);
        chk("t1_adr0", 32'(inst_adr_o), 32'd0);
        chk("t1_state", 32'(state_o), 32'd1);
        tick();
        chk("t1_valid", 32'(ir_valid_o), 32'd1);
        chk("t1_ir",    32'(ir_o), 32'h38A8C);
        chk("t1_pc",    32'(pc_o), 32'd0);
        chk("t1_stb_lo", 32'(inst_stb_o), 32'd0);
        tick();
        chk("t1_valid_1cyc", 32'(ir_valid_o), 32'd0);
        chk("t1_adr1", 32'(inst_adr_o), 32'd1);
        chk("t1_stb1", 32'(inst_stb_o), 32'd1);
        tick();
        chk("t1_pc1", 32'(pc_o), 32'd1);
        tick();
        chk("t1_adr2", 32'(inst_adr_o), 32'd2);
        chk("t1_stb2", 32'(inst_stb_o), 32'd1);
        inst_ack_i = 1'b0; ir_ready_i = 1'b0;

        // ---- ack delayed 3 cycles ----
        for (int i = 0; i < 4; i++) begin
            chk("t2_stb", 32'(inst_stb_o), 32'd1);
            chk("t2_adr", 32'(inst_adr_o), 32'd2);
            chk("t2_novalid", 32'(ir_valid_o), 32'd0);
            if (i == 3) begin
                inst_ack_i = 1'b1; inst_dat_i = 18'h12345;
            end
            tick();
        end
        inst_ack_i = 1'b0;
        chk("t2_valid", 32'(ir_valid_o), 32'd1);
        chk("t2_ir",    32'(ir_o), 32'h12345);
        chk("t2_pc",    32'(pc_o), 32'd2);
        tick();
        chk("t2_valid_held", 32'(ir_valid_o), 32'd1);
        ir_ready_i = 1'b1;
        tick();
        ir_ready_i = 1'b0;
        chk("t2_valid_clr", 32'(ir_valid_o), 32'd0);
        chk("t2_adr3", 32'(inst_adr_o), 32'd3);

        // ---- redirect while waiting for ack ----
        redirect_i = 1'b1; redirect_pc_i = 12'h040;
        tick();
        redirect_i = 1'b0;
        chk("t3_state_flush", 32'(state_o), 32'd3);
        chk("t3_stb_held", 32'(inst_stb_o), 32'd1);
        chk("t3_adr_held", 32'(inst_adr_o), 32'd3);
        inst_ack_i = 1'b1; inst_dat_i = 18'h3FFFF;
        tick();
        inst_ack_i = 1'b0;
        chk("t3_not_presented", 32'(ir_valid_o), 32'd0);
        chk("t3_adr_target", 32'(inst_adr_o), 32'h040);
        chk("t3_stb", 32'(inst_stb_o), 32'd1);

        // ---- redirect and interrupt together in S_HOLD ----
        inst_ack_i = 1'b1; inst_dat_i = 18'h0ABCD;
        tick();
        inst_ack_i = 1'b0;
        chk("t4_pc", 32'(pc_o), 32'h040);
        chk("t4_valid", 32'(ir_valid_o), 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 12'h123; int_take_i = 1'b1; ir_ready_i = 1'b1;
        tick();
        redirect_i = 1'b0; int_take_i = 1'b0; ir_ready_i = 1'b0;
        chk("t4_valid_drop", 32'(ir_valid_o), 32'd0);
        chk("t4_adr_intvec", 32'(inst_adr_o), 32'd1);

        // ---- redirect with ack in the same cycle, then PC wrap ----
        redirect_i = 1'b1; redirect_pc_i = 12'hFFF; inst_ack_i = 1'b1; inst_dat_i = 18'h00003;
        tick();
        redirect_i = 1'b0; inst_ack_i = 1'b0;
        chk("t5_gap_stb", 32'(inst_stb_o), 32'd0);
        chk("t5_gap_valid", 32'(ir_valid_o), 32'd0);
        tick();
        chk("t5_stb", 32'(inst_stb_o), 32'd1);
        chk("t5_adr_fff", 32'(inst_adr_o), 32'hFFF);
        inst_ack_i = 1'b1; inst_dat_i = 18'h2AAAA;
        tick();
        inst_ack_i = 1'b0;
        chk("t5_pc_fff", 32'(pc_o), 32'hFFF);
        chk("t5_ir", 32'(ir_o), 32'h2AAAA);
        ir_ready_i = 1'b1;
        tick();
        ir_ready_i = 1'b0;
        chk("t5_wrap_adr", 32'(inst_adr_o), 32'h000);
        chk("t5_wrap_stb", 32'(inst_stb_o), 32'd1);

        // ---- ack never given ----
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            chk("t6_wait_stb", 32'(inst_stb_o), 32'd1);
            chk("t6_wait_err", 32'(fetch_err_o), 32'd0);
            tick();
        end
        chk("t6_err_set", 32'(fetch_err_o), 32'd1);
        chk("t6_stb_drop", 32'(inst_stb_o), 32'd0);
        chk("t6_state_hold", 32'(state_o), 32'd2);
        chk("t6_valid_low", 32'(ir_valid_o), 32'd0);
        ir_ready_i = 1'b1;
        tick(); tick();
        ir_ready_i = 1'b0;
        chk("t6_parked_err", 32'(fetch_err_o), 32'd1);
        chk("t6_parked_stb", 32'(inst_stb_o), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            chk("t6_wait_stb", 32'(inst_stb_o), 32'd1);
            chk("t6_wait_adr", 32'(inst_adr_o), 32'd0);
            chk("t6_no_err", 32'(fetch_err_o), 32'd0);
            tick();
        end
`endif

        // ---- asynchronous reset mid-transaction ----
        rst_i = 1'b1;
        #1;
        chk_reset_values("async_rst");
        tick();
        rst_i = 1'b0;
        tick();

        // ---- randomized traffic against a transaction-level model ----
        // Model: the next instruction presented comes from the latest
        // redirect/interrupt target, else from the last accepted PC + 1.
        exp_pc = 12'h000;
        prev_stb = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_adr = 12'h0;
        wait_cnt = 0; delay = int'($urandom_range(0, 3)); n_seen = 0;
        for (int c = 0; c < 600; c++) begin
            if (prev_stb && !prev_ack) begin
                chk("rnd_req_held_stb", 32'(inst_stb_o), 32'd1);
                chk("rnd_req_held_adr", 32'(inst_adr_o), 32'(prev_adr));
            end
            if (ir_valid_o && !prev_valid) begin
                n_seen++;
                chk("rnd_pc", 32'(pc_o), 32'(exp_pc));
                chk("rnd_ir", 32'(ir_o), 32'(mem[exp_pc]));
            end

            redirect_i    = ($urandom_range(0, 15) == 0);
            int_take_i    = ($urandom_range(0, 31) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
            ir_ready_i    = 1'($urandom_range(0, 1));
            if (int_take_i)                    exp_pc = 12'h001;
            else if (redirect_i)               exp_pc = redirect_pc_i;
            else if (ir_ready_i && ir_valid_o) exp_pc = exp_pc + 12'h001;

            if (inst_stb_o && wait_cnt >= delay) begin
                inst_ack_i = 1'b1;
                inst_dat_i = mem[inst_adr_o];
                wait_cnt   = 0;
                delay      = int'($urandom_range(0, 3));
            end else begin
                inst_ack_i = 1'b0;
                inst_dat_i = 18'($urandom);
                if (inst_stb_o) wait_cnt++;
            end

            prev_stb = inst_stb_o; prev_ack = inst_ack_i;
            prev_adr = inst_adr_o; prev_valid = ir_valid_o;
            tick();
        end
        chk("rnd_progress", 32'(n_seen > 30), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
